// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests words from instruction memory, presents one
// instruction at a time to the control unit and computes the next pc on consume.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_req_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic        instr_valid_o,
    input  logic        stall_i,
    output logic [31:0] instr_o,
    output logic [5:0]  op_o,
    output logic [5:0]  funct_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    input  logic        pcsrc_i,
    input  logic        jump_i,
    output logic [31:0] retired_o,
    output logic        fetch_err_o
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   retired_q, retired_d;
    logic [WW-1:0] wait_q, wait_d;

    logic [31:0] pcplus4;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;

    assign pcplus4      = pc_q + 32'd4;
    assign branchTarget = pcplus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jumpTarget   = {pcplus4[31:28], instr_q[25:0], 2'b00};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        retired_d     = retired_q;
        wait_d        = wait_q;
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    instr_d = imem_rdata_i;
                    wait_d  = '0;
                    state_d = ISSUE;
                end else begin
                    wait_d = wait_q + WW'(1);
                    if (wait_d == WAIT_LIMIT) begin
                        state_d = ERROR;
                    end
                end
            end
            ISSUE: begin
                instr_valid_o = 1'b1;
                // Branch/jump decisions are only meaningful on the consuming cycle.
                if (!stall_i) begin
                    retired_d = retired_q + 32'd1;
                    wait_d    = '0;
                    state_d   = FETCH;
                    if (jump_i) begin
                        pc_d = jumpTarget;
                    end else if (pcsrc_i) begin
                        pc_d = branchTarget;
                    end else begin
                        pc_d = pcplus4;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign op_o        = instr_q[31:26];
    assign funct_o     = instr_q[5:0];
    assign pc_o        = pc_q;
    assign pcplus4_o   = pcplus4;
    assign retired_o   = retired_q;
    assign fetch_err_o = (state_q == ERROR);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: a small instruction memory model plus
// one task per scenario, each comparing DUT outputs to hand-computed values.
module tb_instr_fetch;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imemAddr;
    logic        imemReq;
    logic [31:0] imemRdata;
    logic        imemReady;
    logic        instrValid;
    logic        stall;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        pcsrc;
    logic        jump;
    logic [31:0] retired;
    logic        fetchErr;

    logic [31:0] memArr [0:63];

    int cmpCount = 0;
    int errCount = 0;

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(MAXW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .imem_addr_o  (imemAddr),
        .imem_req_o   (imemReq),
        .imem_rdata_i (imemRdata),
        .imem_ready_i (imemReady),
        .instr_valid_o(instrValid),
        .stall_i      (stall),
        .instr_o      (instr),
        .op_o         (op),
        .funct_o      (funct),
        .pc_o         (pc),
        .pcplus4_o    (pcplus4),
        .pcsrc_i      (pcsrc),
        .jump_i       (jump),
        .retired_o    (retired),
        .fetch_err_o  (fetchErr)
    );

    always #5 clk = ~clk;

    // One far-away word lets the jump scenario reach 0x0040_0000 without aliasing.
    always_comb begin
        if (imemAddr == 32'h0040_0000) imemRdata = 32'h0800_0040;
        else                           imemRdata = memArr[imemAddr[7:2]];
    end

    task automatic clearMem();
        for (int i = 0; i < 64; i++) memArr[i] = 32'd0;
    endtask

    task automatic doReset();
        reset = 1'b1; imemReady = 1'b1; stall = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic runToIssue(input logic [31:0] addr);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (instrValid === 1'b1 && pc === addr) found = 1;
            else @(negedge clk);
        end
        if (!found) begin
            cmpCount++; errCount++;
            $display("[TB] FAIL runToIssue timeout: pc=%h wanted %h", pc, addr);
        end
    endtask

    task automatic runToFetch(input logic [31:0] addr);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (imemReq === 1'b1 && imemAddr === addr) found = 1;
            else @(negedge clk);
        end
        if (!found) begin
            cmpCount++; errCount++;
            $display("[TB] FAIL runToFetch timeout: imem_addr=%h wanted %h", imemAddr, addr);
        end
    endtask

    task automatic test_reset();
        clearMem();
        reset = 1'b1; imemReady = 1'b1; stall = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmpCount++; if (pc !== 32'h0) begin errCount++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 32'h0); end
        cmpCount++; if (pcplus4 !== 32'h4) begin errCount++; $display("[TB] FAIL reset_pcplus4: got %h want %h", pcplus4, 32'h4); end
        cmpCount++; if (instr !== 32'h0) begin errCount++; $display("[TB] FAIL reset_instr: got %h want %h", instr, 32'h0); end
        cmpCount++; if (instrValid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_valid: got %b want 0", instrValid); end
        cmpCount++; if (retired !== 32'h0) begin errCount++; $display("[TB] FAIL reset_retired: got %h want 0", retired); end
        cmpCount++; if (fetchErr !== 1'b0) begin errCount++; $display("[TB] FAIL reset_err: got %b want 0", fetchErr); end
        reset = 1'b0;
        cmpCount++; if (imemReq !== 1'b1) begin errCount++; $display("[TB] FAIL reset_first_req: got %b want 1", imemReq); end
        cmpCount++; if (imemAddr !== 32'h0) begin errCount++; $display("[TB] FAIL reset_first_addr: got %h want 0", imemAddr); end
    endtask

    task automatic test_sequential();
        clearMem();
        doReset();
        for (int i = 0; i < 3; i++) begin
            cmpCount++;
            if (imemReq !== 1'b1 || imemAddr !== 32'(4 * i)) begin
                errCount++; $display("[TB] FAIL seq_fetch%0d: req=%b addr=%h want req=1 addr=%h", i, imemReq, imemAddr, 32'(4 * i));
            end
            @(negedge clk);
            cmpCount++;
            if (instrValid !== 1'b1 || pc !== 32'(4 * i) || imemReq !== 1'b0) begin
                errCount++; $display("[TB] FAIL seq_issue%0d: valid=%b pc=%h req=%b want 1 %h 0", i, instrValid, pc, imemReq, 32'(4 * i));
            end
            @(negedge clk);
        end
        cmpCount++; if (imemAddr !== 32'hC) begin errCount++; $display("[TB] FAIL seq_addr3: got %h want %h", imemAddr, 32'hC); end
        cmpCount++; if (retired !== 32'd3) begin errCount++; $display("[TB] FAIL seq_retired: got %0d want 3", retired); end
    endtask

    task automatic test_branch();
        clearMem();
        memArr[4] = 32'h1000_0003;
        doReset();
        runToIssue(32'h10);
        pcsrc = 1'b1;
        @(negedge clk);
        pcsrc = 1'b0;
        cmpCount++; if (imemAddr !== 32'h20) begin errCount++; $display("[TB] FAIL branch_fwd: got %h want %h", imemAddr, 32'h20); end
        memArr[4] = 32'h1000_FFFF;
        doReset();
        runToIssue(32'h10);
        pcsrc = 1'b1;
        @(negedge clk);
        pcsrc = 1'b0;
        cmpCount++; if (imemAddr !== 32'h10) begin errCount++; $display("[TB] FAIL branch_back: got %h want %h", imemAddr, 32'h10); end
    endtask

    task automatic test_jump();
        clearMem();
        memArr[0] = 32'h0810_0000;
        doReset();
        runToIssue(32'h0);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        cmpCount++; if (imemAddr !== 32'h0040_0000) begin errCount++; $display("[TB] FAIL jump_first: got %h want %h", imemAddr, 32'h0040_0000); end
        @(negedge clk);
        cmpCount++;
        if (instr !== 32'h0800_0040 || op !== 6'd2 || funct !== 6'd0 || pc !== 32'h0040_0000) begin
            errCount++; $display("[TB] FAIL jump_issue: instr=%h op=%h funct=%h pc=%h want 08000040 02 00 00400000", instr, op, funct, pc);
        end
        jump = 1'b1; pcsrc = 1'b1;
        @(negedge clk);
        jump = 1'b0; pcsrc = 1'b0;
        cmpCount++; if (imemAddr !== 32'h0000_0100) begin errCount++; $display("[TB] FAIL jump_wins: got %h want %h", imemAddr, 32'h100); end
    endtask

    task automatic test_stall();
        clearMem();
        memArr[0] = 32'h1000_0003;
        doReset();
        runToIssue(32'h0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pcsrc = (k % 2 == 0);
            @(negedge clk);
            cmpCount++;
            if (instrValid !== 1'b1 || pc !== 32'h0 || instr !== 32'h1000_0003 || imemReq !== 1'b0 || retired !== 32'd0) begin
                errCount++; $display("[TB] FAIL stall_hold%0d: valid=%b pc=%h instr=%h req=%b retired=%0d", k, instrValid, pc, instr, imemReq, retired);
            end
        end
        stall = 1'b0; pcsrc = 1'b0;
        @(negedge clk);
        cmpCount++; if (imemAddr !== 32'h4) begin errCount++; $display("[TB] FAIL stall_target: got %h want %h", imemAddr, 32'h4); end
        cmpCount++; if (retired !== 32'd1) begin errCount++; $display("[TB] FAIL stall_retired: got %0d want 1", retired); end
    endtask

    task automatic test_wait();
        clearMem();
        memArr[0] = 32'hDEAD_BEEF;
        doReset();
        imemReady = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cmpCount++;
            if (imemReq !== 1'b1 || imemAddr !== 32'h0 || instrValid !== 1'b0) begin
                errCount++; $display("[TB] FAIL wait_hold%0d: req=%b addr=%h valid=%b want 1 0 0", k, imemReq, imemAddr, instrValid);
            end
        end
        imemReady = 1'b1;
        @(negedge clk);
        cmpCount++;
        if (instrValid !== 1'b1 || instr !== 32'hDEAD_BEEF || op !== 6'h37 || funct !== 6'h2F || fetchErr !== 1'b0) begin
            errCount++; $display("[TB] FAIL wait_capture: valid=%b instr=%h op=%h funct=%h err=%b", instrValid, instr, op, funct, fetchErr);
        end
    endtask

    task automatic test_error();
        clearMem();
        doReset();
        imemReady = 1'b0;
        repeat (MAXW - 1) @(negedge clk);
        cmpCount++; if (fetchErr !== 1'b0 || imemReq !== 1'b1) begin errCount++; $display("[TB] FAIL err_early: err=%b req=%b want 0 1", fetchErr, imemReq); end
        @(negedge clk);
        cmpCount++;
        if (fetchErr !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0) begin
            errCount++; $display("[TB] FAIL err_raise: err=%b req=%b valid=%b want 1 0 0", fetchErr, imemReq, instrValid);
        end
        imemReady = 1'b1; pcsrc = 1'b1; jump = 1'b1;
        repeat (3) @(negedge clk);
        pcsrc = 1'b0; jump = 1'b0;
        cmpCount++; if (fetchErr !== 1'b1 || imemReq !== 1'b0) begin errCount++; $display("[TB] FAIL err_sticky: err=%b req=%b want 1 0", fetchErr, imemReq); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmpCount++; if (fetchErr !== 1'b0 || imemReq !== 1'b1) begin errCount++; $display("[TB] FAIL err_clear: err=%b req=%b want 0 1", fetchErr, imemReq); end
    endtask

    task automatic test_reset_mid();
        clearMem();
        doReset();
        runToFetch(32'h8);
        imemReady = 1'b0;
        repeat (2) @(negedge clk);
        cmpCount++; if (retired !== 32'd2) begin errCount++; $display("[TB] FAIL midwait_retired_before: got %0d want 2", retired); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; imemReady = 1'b1;
        cmpCount++;
        if (imemAddr !== 32'h0 || retired !== 32'd0 || fetchErr !== 1'b0 || instrValid !== 1'b0) begin
            errCount++; $display("[TB] FAIL midwait_reset: addr=%h retired=%0d err=%b valid=%b", imemAddr, retired, fetchErr, instrValid);
        end
        runToIssue(32'h4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmpCount++;
        if (retired !== 32'd0 || instrValid !== 1'b0 || imemAddr !== 32'h0) begin
            errCount++; $display("[TB] FAIL issue_reset: retired=%0d valid=%b addr=%h want 0 0 0", retired, instrValid, imemAddr);
        end
    endtask

    task automatic test_wrap();
        clearMem();
        memArr[0] = 32'h1000_FFFE;
        doReset();
        runToIssue(32'h0);
        pcsrc = 1'b1;
        @(negedge clk);
        pcsrc = 1'b0;
        cmpCount++; if (imemAddr !== 32'hFFFF_FFFC) begin errCount++; $display("[TB] FAIL wrap_target: got %h want FFFFFFFC", imemAddr); end
        @(negedge clk);
        cmpCount++; if (pcplus4 !== 32'h0) begin errCount++; $display("[TB] FAIL wrap_pcplus4: got %h want 0", pcplus4); end
        @(negedge clk);
        cmpCount++;
        if (imemAddr !== 32'h0 || retired !== 32'd2 || fetchErr !== 1'b0) begin
            errCount++; $display("[TB] FAIL wrap_next: addr=%h retired=%0d err=%b want 0 2 0", imemAddr, retired, fetchErr);
        end
    endtask

    initial begin
        reset = 1'b1; imemReady = 1'b1; stall = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        clearMem();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_wait();
        test_error();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter MAX_WAIT, default 16, imem wait-cycle limit before fetch_err is raised.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_req  output  1  fetch request, held until imem_ready is seen.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-008 imem_ready  input  1  memory completes the request in this cycle.
REQ-009 instr_valid  output  1  instr/op/funct/pc/pcplus4 hold a valid instruction for the control unit.
REQ-010 stall  input  1  downstream cannot consume the presented instruction this cycle.
REQ-011 instr  output  32  registered instruction word.
REQ-012 op  output  6  instr[31:26]; funct  output  6  instr[5:0] (feed control_unity op/funct).
REQ-013 pc  output  32  address of the presented instruction; pcplus4  output  32  pc+4.
REQ-014 pcsrc  input  1  branch-taken from control unit; jump  input  1  jump from control unit.
REQ-015 retired  output  32  count of instructions consumed since reset.
REQ-016 fetch_err  output  1  sticky; memory exceeded MAX_WAIT wait cycles.

Function
REQ-017 FSM states: FETCH, ISSUE, ERROR.
REQ-018 FETCH: imem_req=1, imem_addr=pc_reg, instr_valid=0.
REQ-019 FETCH and imem_ready=1: instr <- imem_rdata at that edge; next state ISSUE; zero-wait memory gives instr_valid one cycle after imem_req rises.
REQ-020 FETCH and imem_ready=0: wait counter increments; when counter reaches MAX_WAIT with imem_ready still 0 -> ERROR.
REQ-021 ISSUE: instr_valid=1, imem_req=0; instr, op, funct, pc, pcplus4 held stable while stall=1.
REQ-022 ISSUE and stall=0: instruction consumed; pcsrc and jump sampled only in this cycle; retired+1; next state FETCH.
REQ-023 Next pc when consumed: jump=1 -> {pcplus4[31:28], instr[25:0], 2'b00}; else pcsrc=1 -> pcplus4 + (signext(instr[15:0]) << 2); else pcplus4.
REQ-024 jump and pcsrc both 1: jump wins.
REQ-025 Address arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 without flag.
REQ-026 retired wraps 32'hFFFF_FFFF -> 0.
REQ-027 pcsrc/jump ignored in FETCH, in ISSUE with stall=1, and in ERROR.
REQ-028 ERROR: imem_req=0, instr_valid=0, fetch_err=1; leave only by reset.
REQ-029 imem_ready in ISSUE or ERROR ignored; imem_rdata never captured outside FETCH.
REQ-030 Wait counter clears on entry to FETCH.

Reset
REQ-031 reset=1 at a clock edge: state FETCH, pc=RESET_PC, pcplus4=RESET_PC+4, instr=0, instr_valid=0, retired=0, fetch_err=0, wait counter=0.
REQ-032 imem_req=1 in the first cycle after reset deasserts (FETCH entered).
REQ-033 Reset wins over every other input in the same cycle, including mid-wait in FETCH (request abandoned) and in ISSUE (instruction dropped, not counted).

Verification
REQ-034 Sequential: RESET_PC=0, imem_ready=1 always, stall=0, pcsrc=jump=0 -> imem_addr 0,4,8,12 on successive fetches; retired=3 after third consume.
REQ-035 Branch: instr=32'h1000_0003 at pc=0x10, pcsrc=1 on consume -> next imem_addr=0x20; backward imm 16'hFFFF at pc=0x10 -> 0x10.
REQ-036 Jump: instr=32'h0800_0040 at pc=0x0040_0000, jump=1, pcsrc=1 -> next imem_addr=0x0000_0100.
REQ-037 Stall: stall=1 for 3 cycles in ISSUE with pcsrc toggling -> outputs stable, retired unchanged, no imem_req; target from pcsrc at stall=0 cycle only.
REQ-038 Wait/error: imem_ready=0 for 2 cycles then 1 -> instr captured, no error; imem_ready=0 for MAX_WAIT cycles -> fetch_err=1, imem_req=0 until reset.
REQ-039 Reset mid-wait at pc=0x8 -> next cycle imem_addr=RESET_PC, retired=0, fetch_err=0.
